// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    // Controller FSM states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    // Width of each of the WB/M/EX control fields in the ID/EX register.
    localparam int CTRL_W = 2;

    // Value the ID/EX control fields take when a bubble is inserted.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller: load-use bubbles, branch flushes, memory
// freeze with hang timeout, and saturating stall/flush counters.
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int WAIT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  pipe_hold,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);
    import hazard_pkg::*;

    // Wait count at which one more frozen cycle exhausts the timeout.
    localparam logic [WAIT_W-1:0] LAST_WAIT   = WAIT_W'(MEM_TIMEOUT - 1);
    // With a timeout of one, the very first frozen cycle in RUN halts.
    localparam bit                TIMEOUT_ONE = (MEM_TIMEOUT == 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              freeze;

    // Hazard detection: load-use match and memory freeze for the current state.
    always_comb begin
        load_use = ex_mem_read && (ex_rd != '0) &&
                   ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                    (id_uses_rs2 && (ex_rd == id_rs2)));
        freeze   = 1'b0;
        case (state)
            RUN:      freeze = mem_req && !mem_ready;
            MEM_WAIT: freeze = !mem_ready;
            default:  freeze = 1'b0;
        endcase
    end

    // Pipeline control outputs, priority freeze > branch flush > load-use.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b0;
        halted       = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (state == HALT) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            pipe_hold    = 1'b1;
            halted       = 1'b1;
        end else if (freeze) begin
            // EX is held too, so a pending branch is re-presented afterwards.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            pipe_hold    = 1'b1;
        end else if (branch_taken) begin
            // Redirect wins over a coincident load-use; the ID instruction dies.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Freeze/timeout state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        if (TIMEOUT_ONE) begin
                            state <= HALT;
                        end else begin
                            state    <= MEM_WAIT;
                            wait_cnt <= WAIT_W'(1);
                        end
                    end
                end
                MEM_WAIT: begin
                    if (!freeze) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!pc_write),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (if_id_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_hazard_stall_ctrl;

    localparam int RW   = 5;
    localparam int CW   = 4;
    localparam int TMO  = 4;
    localparam int WW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic          branch_taken, mem_req, mem_ready;
    logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, halted;
    logic [CW-1:0] stall_cycles, flush_count;

    int n_cmp = 0;
    int n_err = 0;

    hazard_stall_ctrl #(
        .REG_ADDR_W (RW),
        .CNT_W      (CW),
        .MEM_TIMEOUT(TMO),
        .WAIT_W     (WW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .branch_taken(branch_taken),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .if_id_flush (if_id_flush),
        .id_ex_bubble(id_ex_bubble),
        .pipe_hold   (pipe_hold),
        .halted      (halted),
        .stall_cycles(stall_cycles),
        .flush_count (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit armed    = 1'b0;
    bit m_halted = 1'b0;
    int m_frozen = 0;   // consecutive frozen cycles so far
    int m_stall  = 0;
    int m_flush  = 0;

    always @(negedge clk) begin
        bit e_pc, e_ifw, e_fl, e_bub, e_hold, e_halt, frz, lu;
        lu  = ex_mem_read && (ex_rd != 0) &&
              ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
        frz = (m_frozen > 0) ? !mem_ready : (mem_req && !mem_ready);
        {e_pc, e_ifw, e_fl, e_bub, e_hold, e_halt} = 6'b110000;
        if (rst)               {e_pc, e_ifw, e_fl, e_bub, e_hold, e_halt} = 6'b000100;
        else if (m_halted)     {e_pc, e_ifw, e_fl, e_bub, e_hold, e_halt} = 6'b000111;
        else if (frz)          {e_pc, e_ifw, e_fl, e_bub, e_hold, e_halt} = 6'b000010;
        else if (branch_taken) {e_pc, e_ifw, e_fl, e_bub, e_hold, e_halt} = 6'b111100;
        else if (lu)           {e_pc, e_ifw, e_fl, e_bub, e_hold, e_halt} = 6'b000100;

        if (armed) begin
            check("pc_write",     64'(pc_write),     64'(e_pc));
            check("if_id_write",  64'(if_id_write),  64'(e_ifw));
            check("if_id_flush",  64'(if_id_flush),  64'(e_fl));
            check("id_ex_bubble", 64'(id_ex_bubble), 64'(e_bub));
            check("pipe_hold",    64'(pipe_hold),    64'(e_hold));
            check("halted",       64'(halted),       64'(e_halt));
            check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
            check("flush_count",  64'(flush_count),  64'(m_flush));
        end

        if (rst) begin
            armed    = 1'b1;
            m_halted = 1'b0;
            m_frozen = 0;
            m_stall  = 0;
            m_flush  = 0;
        end else begin
            if (!e_pc && m_stall < CMAX) m_stall++;
            if (e_fl && m_flush < CMAX)  m_flush++;
            if (!m_halted) begin
                if (frz) begin
                    m_frozen++;
                    if (m_frozen >= TMO) m_halted = 1'b1;
                end else begin
                    m_frozen = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use(input logic [RW-1:0] rd);
        idle();
        ex_mem_read = 1; ex_rd = rd; id_rs2 = rd; id_uses_rs2 = 1;
    endtask

    initial begin
        int hang;
        // Reset with random inputs
        rst = 1;
        id_rs1 = RW'($urandom); id_rs2 = RW'($urandom); ex_rd = RW'($urandom);
        {id_uses_rs1, id_uses_rs2, ex_mem_read, branch_taken, mem_req, mem_ready} = 6'($urandom);
        tick();
        @(negedge clk);
        check("rst_bubble", 64'(id_ex_bubble), 64'd1);
        check("rst_pc",     64'(pc_write),     64'd0);
        check("rst_stall",  64'(stall_cycles), 64'd0);
        check("rst_flush",  64'(flush_count),  64'd0);
        tick();
        rst = 0;
        idle();
        @(negedge clk);
        check("run_pc",  64'(pc_write),    64'd1);
        check("run_ifw", 64'(if_id_write), 64'd1);
        tick();

        // Load-use stall, then the same with x0
        load_use(5);
        @(negedge clk);
        check("lu_pc",  64'(pc_write),     64'd0);
        check("lu_ifw", 64'(if_id_write),  64'd0);
        check("lu_bub", 64'(id_ex_bubble), 64'd1);
        tick();
        load_use(0);
        @(negedge clk);
        check("lu_x0_pc",    64'(pc_write),     64'd1);
        check("lu_stall_cnt", 64'(stall_cycles), 64'd1);
        tick();

        // Branch with coincident load-use
        load_use(5);
        branch_taken = 1;
        @(negedge clk);
        check("br_flush", 64'(if_id_flush),  64'd1);
        check("br_bub",   64'(id_ex_bubble), 64'd1);
        check("br_pc",    64'(pc_write),     64'd1);
        tick();
        idle();
        @(negedge clk);
        check("br_flush_cnt", 64'(flush_count),  64'd1);
        check("br_stall_cnt", 64'(stall_cycles), 64'd1);
        tick();

        // Memory wait of 3 cycles with a branch held across it
        idle();
        mem_req = 1; branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mw_hold",  64'(pipe_hold),   64'd1);
            check("mw_flush", 64'(if_id_flush), 64'd0);
            tick();
        end
        mem_ready = 1;
        @(negedge clk);
        check("mw_rdy_hold",  64'(pipe_hold),   64'd0);
        check("mw_rdy_flush", 64'(if_id_flush), 64'd1);
        tick();
        idle();
        @(negedge clk);
        check("mw_stall_cnt", 64'(stall_cycles), 64'd4);
        check("mw_flush_cnt", 64'(flush_count),  64'd2);
        tick();

        // Timeout: hung memory halts after 4 frozen cycles
        idle();
        mem_req = 1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            check("to_not_halted", 64'(halted),    64'd0);
            check("to_hold",       64'(pipe_hold), 64'd1);
            tick();
        end
        @(negedge clk);
        check("to_halted", 64'(halted),       64'd1);
        check("to_bub",    64'(id_ex_bubble), 64'd1);
        check("to_pc",     64'(pc_write),     64'd0);
        tick();
        mem_ready = 1; branch_taken = 1;
        @(negedge clk);
        check("to_halt_sticky", 64'(halted),       64'd1);
        check("to_stall_cnt",   64'(stall_cycles), 64'd9);
        tick();
        rst = 1;
        tick();
        rst = 0;
        idle();
        @(negedge clk);
        check("to_rst_halted", 64'(halted),   64'd0);
        check("to_rst_pc",     64'(pc_write), 64'd1);
        tick();

        // Saturation: 20 load-use stalls on a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            load_use(RW'(7));
            tick();
        end
        idle();
        @(negedge clk);
        check("sat_stall", 64'(stall_cycles), 64'd15);
        tick();

        // Randomized traffic
        hang = 0;
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 79) == 0);
            id_rs1       = RW'($urandom_range(0, 3));
            id_rs2       = RW'($urandom_range(0, 3));
            ex_rd        = RW'($urandom_range(0, 3));
            id_uses_rs1  = 1'($urandom);
            id_uses_rs2  = 1'($urandom);
            ex_mem_read  = ($urandom_range(0, 2) == 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            mem_req      = ($urandom_range(0, 2) == 0);
            if (hang == 0 && $urandom_range(0, 39) == 0) hang = $urandom_range(2, 7);
            if (hang > 0) begin
                mem_ready = 0;
                hang--;
            end else begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
